// File: rtl/ibox_issue.sv
// Issue/writeback stage around the integer execution box: decodes operate-format
// instructions, forms registered operands and control, tracks hazards and raises precise traps.
module ibox_issue #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [6:0]  in_func,
    input  logic [4:0]  in_ra,
    input  logic [4:0]  in_rb,
    input  logic [4:0]  in_rc,
    input  logic        in_lit_en,
    input  logic [7:0]  in_lit,
    input  logic [63:0] in_pc,
    output logic [4:0]  rf_a_addr,
    output logic [4:0]  rf_b_addr,
    input  logic [63:0] rf_a_data,
    input  logic [63:0] rf_b_data,
    output logic [63:0] a,
    output logic [63:0] b,
    output logic [30:0] control,
    input  logic [63:0] ibox_result,
    input  logic        ibox_flag,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [63:0] wb_data,
    output logic        trap,
    output logic [1:0]  trap_cause,
    input  logic        trap_ack,
    output logic [63:0] trap_pc
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic        ex_valid_reg;
    logic [4:0]  ex_rc_reg;
    logic [63:0] ex_pc_reg;
    logic [63:0] a_reg;
    logic [63:0] b_reg;
    logic [30:0] control_reg;
    logic        wb_valid_reg;
    logic [4:0]  wb_addr_reg;
    logic [1:0]  trap_cause_reg;
    logic [63:0] trap_pc_reg;

    logic        dec_legal;
    logic [1:0]  dec_shifter;
    logic [3:0]  dec_alu;
    logic [2:0]  dec_cmp;
    logic        dec_mux0;
    logic [2:0]  dec_mux2;
    logic        dec_v;
    logic [30:0] dec_control;

    always_comb begin
        dec_legal   = 1'b1;
        dec_shifter = 2'b00;
        dec_alu     = 4'd0;
        dec_cmp     = 3'd0;
        dec_mux0    = 1'b0;
        dec_mux2    = 3'd0;
        dec_v       = 1'b0;
        case (in_opcode)
            6'h10: begin
                case (in_func)
                    7'h20: dec_alu = 4'd1;
                    7'h00: begin dec_alu = 4'd1; dec_mux2 = 3'd1; end
                    7'h29: dec_alu = 4'd2;
                    7'h09: begin dec_alu = 4'd2; dec_mux2 = 3'd1; end
                    7'h60: begin dec_alu = 4'd1; dec_v = 1'b1; end
                    7'h40: begin dec_alu = 4'd1; dec_mux2 = 3'd1; dec_v = 1'b1; end
                    7'h69: begin dec_alu = 4'd2; dec_v = 1'b1; end
                    7'h49: begin dec_alu = 4'd2; dec_mux2 = 3'd1; dec_v = 1'b1; end
                    7'h2D: begin dec_alu = 4'd2; dec_cmp = 3'd2; dec_mux2 = 3'd2; end
                    7'h4D: begin dec_alu = 4'd2; dec_cmp = 3'd0; dec_mux2 = 3'd2; end
                    7'h1D: begin dec_alu = 4'd2; dec_cmp = 3'd5; dec_mux2 = 3'd2; end
                    7'h6D: begin dec_alu = 4'd2; dec_cmp = 3'd3; dec_mux2 = 3'd2; end
                    7'h3D: begin dec_alu = 4'd2; dec_cmp = 3'd6; dec_mux2 = 3'd2; end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h11: begin
                case (in_func)
                    7'h00: dec_alu = 4'd3;
                    7'h20: dec_alu = 4'd4;
                    7'h40: dec_alu = 4'd5;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h12: begin
                case (in_func)
                    7'h39: begin dec_shifter = 2'b00; dec_mux0 = 1'b1; end
                    7'h34: begin dec_shifter = 2'b10; dec_mux0 = 1'b1; end
                    7'h3C: begin dec_shifter = 2'b11; dec_mux0 = 1'b1; end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h13: begin
                case (in_func)
                    7'h20: dec_alu = 4'd7;
                    7'h00: dec_alu = 4'd8;
                    7'h30: dec_alu = 4'd9;
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // {n_shift, shifter, alu, cmp, mei, xor, mux0, mux1, mux2, mux3, v}
    assign dec_control = {6'd0, dec_shifter, dec_alu, dec_cmp, 5'd0, 3'd0,
                          dec_mux0, 1'b0, dec_mux2, 2'b00, dec_v};

    logic [1:0][4:0]  src_addr;
    logic [1:0][63:0] src_rf;
    logic [1:0][63:0] src_val;
    logic [1:0]       src_used;
    logic [1:0]       hz_ex;
    logic [1:0]       hz_wb;
    logic             hazard;
    logic [63:0]      operand_b;

    assign src_addr[0] = in_ra;
    assign src_addr[1] = in_rb;
    assign src_rf[0]   = rf_a_data;
    assign src_rf[1]   = rf_b_data;
    assign src_used[0] = 1'b1;
    assign src_used[1] = !in_lit_en;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic wb_hit;
            assign wb_hit      = wb_valid_reg && (wb_addr_reg == src_addr[gi]);
            assign src_val[gi] = (src_addr[gi] == 5'd31) ? 64'd0 :
                                 ((BYPASS != 0) && wb_hit) ? ibox_result : src_rf[gi];
            assign hz_ex[gi]   = src_used[gi] && ex_valid_reg && (ex_rc_reg != 5'd31) &&
                                 (ex_rc_reg == src_addr[gi]);
            // Without forwarding the WB value only becomes readable after the RF write.
            assign hz_wb[gi]   = (BYPASS == 0) && src_used[gi] && wb_hit;
        end
    endgenerate

    assign hazard    = (|hz_ex) || (|hz_wb);
    assign operand_b = in_lit_en ? {56'd0, in_lit} : src_val[1];

    logic accept;
    logic issue;
    logic ovf_trap;
    logic ill_trap;

    assign in_ready = (state_reg == RUN) && !rst && !hazard && !ibox_flag;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && dec_legal;
    assign ill_trap = accept && !dec_legal;
    assign ovf_trap = ex_valid_reg && ibox_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (ovf_trap || ill_trap) state_next = TRAP;
            TRAP:    if (trap_ack) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg <= 1'b0;
            ex_rc_reg    <= 5'd0;
            ex_pc_reg    <= 64'd0;
            a_reg        <= 64'd0;
            b_reg        <= 64'd0;
            control_reg  <= 31'd0;
        end else if (issue) begin
            ex_valid_reg <= 1'b1;
            ex_rc_reg    <= in_rc;
            ex_pc_reg    <= in_pc;
            a_reg        <= src_val[0];
            b_reg        <= operand_b;
            control_reg  <= dec_control;
        end else begin
            ex_valid_reg <= 1'b0;
            control_reg  <= 31'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= 5'd0;
        end else begin
            // An overflowing instruction must not retire its result.
            wb_valid_reg <= ex_valid_reg && !ibox_flag && (ex_rc_reg != 5'd31);
            wb_addr_reg  <= ex_rc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_cause_reg <= 2'd0;
            trap_pc_reg    <= 64'd0;
        end else if (state_reg == RUN) begin
            if (ovf_trap) begin
                trap_cause_reg <= 2'd1;
                trap_pc_reg    <= ex_pc_reg;
            end else if (ill_trap) begin
                trap_cause_reg <= 2'd2;
                trap_pc_reg    <= in_pc;
            end
        end
    end

    assign rf_a_addr  = in_ra;
    assign rf_b_addr  = in_rb;
    assign a          = a_reg;
    assign b          = b_reg;
    assign control    = control_reg;
    assign wb_valid   = wb_valid_reg;
    assign wb_addr    = wb_addr_reg;
    assign wb_data    = ibox_result;
    assign trap       = (state_reg == TRAP);
    assign trap_cause = trap_cause_reg;
    assign trap_pc    = trap_pc_reg;

endmodule

// File: tb/tb_ibox_issue.sv
// Directed bench for ibox_issue: two instances (forwarding on/off), each with its own
// register-file and Ibox model; one task per scenario with inline comparisons.
module tb_ibox_issue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  in_valid;
    logic [5:0]  in_opcode;
    logic [6:0]  in_func;
    logic [4:0]  in_ra, in_rb, in_rc;
    logic        in_lit_en;
    logic [7:0]  in_lit;
    logic [63:0] in_pc;
    logic        trap_ack;

    logic [1:0]  in_ready;
    logic [4:0]  rf_a_addr [2];
    logic [4:0]  rf_b_addr [2];
    logic [63:0] rf_a_data [2];
    logic [63:0] rf_b_data [2];
    logic [63:0] a_o [2];
    logic [63:0] b_o [2];
    logic [30:0] ctrl [2];
    logic [63:0] ibox_res [2];
    logic [1:0]  ibox_flag;
    logic [1:0]  wb_valid;
    logic [4:0]  wb_addr [2];
    logic [63:0] wb_data [2];
    logic [1:0]  trap;
    logic [1:0]  trap_cause [2];
    logic [63:0] trap_pc [2];

    logic [63:0] rf_m [2][32];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] rf_init(input int r);
        case (r)
            1:       return 64'd5;
            2:       return 64'd7;
            6:       return 64'h7FFF_FFFF_FFFF_FFFF;
            10:      return 64'd1;
            31:      return 64'hDEAD_BEEF_0000_0031;
            default: return 64'h1000 + 64'(r);
        endcase
    endfunction

    function automatic logic [63:0] ibox_calc(input logic [30:0] c, input logic [63:0] x, input logic [63:0] y);
        if (c[7]) begin
            case (c[24:23])
                2'b00:   return x << y[5:0];
                2'b10:   return x >> y[5:0];
                2'b11:   return $signed(x) >>> y[5:0];
                default: return 64'd0;
            endcase
        end
        case (c[22:19])
            4'd1:    return x + y;
            4'd2:    return x - y;
            4'd3:    return x & y;
            4'd4:    return x | y;
            4'd5:    return x ^ y;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ibox_ovf(input logic [30:0] c, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] s, d;
        s = x + y;
        d = x - y;
        if (!c[0]) return 1'b0;
        if (c[22:19] == 4'd1) return (x[63] == y[63]) && (s[63] != x[63]);
        if (c[22:19] == 4'd2) return (x[63] != y[63]) && (d[63] != x[63]);
        return 1'b0;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            ibox_issue #(.BYPASS(gi == 0 ? 1 : 0)) dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid[gi]),
                .in_ready   (in_ready[gi]),
                .in_opcode  (in_opcode),
                .in_func    (in_func),
                .in_ra      (in_ra),
                .in_rb      (in_rb),
                .in_rc      (in_rc),
                .in_lit_en  (in_lit_en),
                .in_lit     (in_lit),
                .in_pc      (in_pc),
                .rf_a_addr  (rf_a_addr[gi]),
                .rf_b_addr  (rf_b_addr[gi]),
                .rf_a_data  (rf_a_data[gi]),
                .rf_b_data  (rf_b_data[gi]),
                .a          (a_o[gi]),
                .b          (b_o[gi]),
                .control    (ctrl[gi]),
                .ibox_result(ibox_res[gi]),
                .ibox_flag  (ibox_flag[gi]),
                .wb_valid   (wb_valid[gi]),
                .wb_addr    (wb_addr[gi]),
                .wb_data    (wb_data[gi]),
                .trap       (trap[gi]),
                .trap_cause (trap_cause[gi]),
                .trap_ack   (trap_ack),
                .trap_pc    (trap_pc[gi])
            );
            assign rf_a_data[gi] = rf_m[gi][rf_a_addr[gi]];
            assign rf_b_data[gi] = rf_m[gi][rf_b_addr[gi]];
            assign ibox_flag[gi] = ibox_ovf(ctrl[gi], a_o[gi], b_o[gi]);
        end
    endgenerate

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int j = 0; j < 32; j++) rf_m[i][j] <= rf_init(j);
                ibox_res[i] <= 64'd0;
            end else begin
                if (wb_valid[i]) rf_m[i][wb_addr[i]] <= wb_data[i];
                ibox_res[i] <= ibox_calc(ctrl[i], a_o[i], b_o[i]);
            end
        end
    end

    task automatic drive(input int i, input logic [5:0] op, input logic [6:0] fn,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                         input logic le, input logic [7:0] lit, input logic [63:0] pc);
        in_opcode = op; in_func = fn; in_ra = ra; in_rb = rb; in_rc = rc;
        in_lit_en = le; in_lit = lit; in_pc = pc;
        in_valid = 2'b00;
        in_valid[i] = 1'b1;
    endtask

    // Holds the instruction until accepted; returns the number of stall cycles.
    task automatic issue(input int i, input logic [5:0] op, input logic [6:0] fn,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                         input logic le, input logic [7:0] lit, input logic [63:0] pc,
                         output int stalls);
        logic acc;
        acc = 1'b0;
        stalls = 0;
        drive(i, op, fn, ra, rb, rc, le, lit, pc);
        for (int k = 0; k < 20 && !acc; k++) begin
            #1;
            acc = in_ready[i];
            @(posedge clk);
            #1;
            if (!acc) stalls++;
        end
        in_valid = 2'b00;
        $display("issue inst%0d op=%h.%h pc=%h stalls=%0d", i, op, fn, pc, stalls);
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL issue_timeout inst%0d pc=%h: not accepted within 20 cycles", i, pc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 2'b00; trap_ack = 1'b0;
        in_opcode = '0; in_func = '0; in_ra = '0; in_rb = '0; in_rc = '0;
        in_lit_en = 1'b0; in_lit = '0; in_pc = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_ack();
        trap_ack = 1'b1;
        @(posedge clk); #1;
        trap_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 2'b00; trap_ack = 1'b0;
        in_opcode = '0; in_func = '0; in_ra = '0; in_rb = '0; in_rc = '0;
        in_lit_en = 1'b0; in_lit = '0; in_pc = '0;
        @(posedge clk); #1;
        in_valid = 2'b11;
        #1;
        n_cmp++; if (in_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (a_o[i] !== 64'd0) begin n_bad++; $display("FAIL reset_a%0d got %h want 0", i, a_o[i]); end
            n_cmp++; if (b_o[i] !== 64'd0) begin n_bad++; $display("FAIL reset_b%0d got %h want 0", i, b_o[i]); end
            n_cmp++; if (ctrl[i] !== 31'd0) begin n_bad++; $display("FAIL reset_control%0d got %h want 0", i, ctrl[i]); end
            n_cmp++; if (wb_valid[i] !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid%0d got %b want 0", i, wb_valid[i]); end
            n_cmp++; if (wb_addr[i] !== 5'd0) begin n_bad++; $display("FAIL reset_wb_addr%0d got %0d want 0", i, wb_addr[i]); end
            n_cmp++; if (trap[i] !== 1'b0) begin n_bad++; $display("FAIL reset_trap%0d got %b want 0", i, trap[i]); end
            n_cmp++; if (trap_cause[i] !== 2'd0) begin n_bad++; $display("FAIL reset_cause%0d got %0d want 0", i, trap_cause[i]); end
            n_cmp++; if (trap_pc[i] !== 64'd0) begin n_bad++; $display("FAIL reset_trap_pc%0d got %h want 0", i, trap_pc[i]); end
        end
        #1;
        n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL reset_ready_after got %b want 11", in_ready); end
    endtask

    task automatic test_independent();
        int s;
        do_reset();
        issue(0, 6'h10, 7'h20, 5'd1, 5'd2, 5'd3, 1'b0, 8'd0, 64'h100, s);
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL indep_stall0 got %0d want 0", s); end
        n_cmp++; if (a_o[0] !== 64'd5) begin n_bad++; $display("FAIL indep_a got %h want 5", a_o[0]); end
        n_cmp++; if (b_o[0] !== 64'd7) begin n_bad++; $display("FAIL indep_b got %h want 7", b_o[0]); end
        n_cmp++; if (ctrl[0] !== 31'h0008_0000) begin n_bad++; $display("FAIL indep_ctrl_addq got %h want 00080000", ctrl[0]); end
        issue(0, 6'h11, 7'h20, 5'd1, 5'd2, 5'd5, 1'b0, 8'd0, 64'h104, s);
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL indep_stall1 got %0d want 0", s); end
        n_cmp++; if (ctrl[0] !== 31'h0020_0000) begin n_bad++; $display("FAIL indep_ctrl_bis got %h want 00200000", ctrl[0]); end
        n_cmp++; if (wb_valid[0] !== 1'b1) begin n_bad++; $display("FAIL indep_wb_valid0 got %b want 1", wb_valid[0]); end
        n_cmp++; if (wb_addr[0] !== 5'd3) begin n_bad++; $display("FAIL indep_wb_addr0 got %0d want 3", wb_addr[0]); end
        n_cmp++; if (wb_data[0] !== 64'd12) begin n_bad++; $display("FAIL indep_wb_data0 got %h want c", wb_data[0]); end
        @(posedge clk); #1;
        n_cmp++; if (wb_valid[0] !== 1'b1) begin n_bad++; $display("FAIL indep_wb_valid1 got %b want 1", wb_valid[0]); end
        n_cmp++; if (wb_addr[0] !== 5'd5) begin n_bad++; $display("FAIL indep_wb_addr1 got %0d want 5", wb_addr[0]); end
        n_cmp++; if (wb_data[0] !== 64'd7) begin n_bad++; $display("FAIL indep_wb_data1 got %h want 7", wb_data[0]); end
        n_cmp++; if (rf_m[0][3] !== 64'd12) begin n_bad++; $display("FAIL indep_rf3 got %h want c", rf_m[0][3]); end
    endtask

    task automatic test_back_to_back();
        int s;
        for (int i = 0; i < 2; i++) begin
            do_reset();
            issue(i, 6'h10, 7'h20, 5'd1, 5'd2, 5'd3, 1'b0, 8'd0, 64'h200, s);
            issue(i, 6'h10, 7'h29, 5'd3, 5'd1, 5'd4, 1'b0, 8'd0, 64'h204, s);
            n_cmp++; if (s !== i + 1) begin n_bad++; $display("FAIL b2b_stalls inst%0d got %0d want %0d", i, s, i + 1); end
            n_cmp++; if (a_o[i] !== 64'd12) begin n_bad++; $display("FAIL b2b_a inst%0d got %h want c", i, a_o[i]); end
            n_cmp++; if (b_o[i] !== 64'd5) begin n_bad++; $display("FAIL b2b_b inst%0d got %h want 5", i, b_o[i]); end
            n_cmp++; if (ctrl[i] !== 31'h0010_0000) begin n_bad++; $display("FAIL b2b_ctrl inst%0d got %h want 00100000", i, ctrl[i]); end
            @(posedge clk); #1;
            n_cmp++; if (wb_valid[i] !== 1'b1) begin n_bad++; $display("FAIL b2b_wb_valid inst%0d got %b want 1", i, wb_valid[i]); end
            n_cmp++; if (wb_addr[i] !== 5'd4) begin n_bad++; $display("FAIL b2b_wb_addr inst%0d got %0d want 4", i, wb_addr[i]); end
            n_cmp++; if (wb_data[i] !== 64'd7) begin n_bad++; $display("FAIL b2b_wb_data inst%0d got %h want 7", i, wb_data[i]); end
        end
    endtask

    task automatic test_overflow();
        int s;
        do_reset();
        issue(0, 6'h10, 7'h60, 5'd6, 5'd0, 5'd7, 1'b1, 8'd1, 64'h300, s);
        n_cmp++; if (ctrl[0] !== 31'h0008_0001) begin n_bad++; $display("FAIL ovf_ctrl got %h want 00080001", ctrl[0]); end
        n_cmp++; if (b_o[0] !== 64'd1) begin n_bad++; $display("FAIL ovf_b got %h want 1", b_o[0]); end
        drive(0, 6'h10, 7'h20, 5'd1, 5'd2, 5'd8, 1'b0, 8'd0, 64'h304);
        #1;
        n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_ready_flag got %b want 0", in_ready[0]); end
        @(posedge clk); #1;
        n_cmp++; if (trap[0] !== 1'b1) begin n_bad++; $display("FAIL ovf_trap got %b want 1", trap[0]); end
        n_cmp++; if (trap_cause[0] !== 2'd1) begin n_bad++; $display("FAIL ovf_cause got %0d want 1", trap_cause[0]); end
        n_cmp++; if (trap_pc[0] !== 64'h300) begin n_bad++; $display("FAIL ovf_trap_pc got %h want 300", trap_pc[0]); end
        n_cmp++; if (wb_valid[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_wb_valid got %b want 0", wb_valid[0]); end
        n_cmp++; if (ctrl[0] !== 31'd0) begin n_bad++; $display("FAIL ovf_younger_ctrl got %h want 0", ctrl[0]); end
        #1;
        n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_ready_trap got %b want 0", in_ready[0]); end
        in_valid = 2'b00;
        pulse_ack();
        n_cmp++; if (trap[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_trap_clear got %b want 0", trap[0]); end
        n_cmp++; if (rf_m[0][7] !== 64'h1007) begin n_bad++; $display("FAIL ovf_rf7 got %h want 1007", rf_m[0][7]); end
        issue(0, 6'h10, 7'h20, 5'd1, 5'd2, 5'd8, 1'b0, 8'd0, 64'h304, s);
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL ovf_resume_stall got %0d want 0", s); end
        n_cmp++; if (ctrl[0] !== 31'h0008_0000) begin n_bad++; $display("FAIL ovf_resume_ctrl got %h want 00080000", ctrl[0]); end
    endtask

    task automatic test_illegal();
        int s;
        do_reset();
        issue(0, 6'h10, 7'h20, 5'd1, 5'd2, 5'd3, 1'b0, 8'd0, 64'h400, s);
        issue(0, 6'h10, 7'h7F, 5'd4, 5'd5, 5'd9, 1'b0, 8'd0, 64'h404, s);
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL ill_stall got %0d want 0", s); end
        n_cmp++; if (trap[0] !== 1'b1) begin n_bad++; $display("FAIL ill_trap got %b want 1", trap[0]); end
        n_cmp++; if (trap_cause[0] !== 2'd2) begin n_bad++; $display("FAIL ill_cause got %0d want 2", trap_cause[0]); end
        n_cmp++; if (trap_pc[0] !== 64'h404) begin n_bad++; $display("FAIL ill_trap_pc got %h want 404", trap_pc[0]); end
        n_cmp++; if (ctrl[0] !== 31'd0) begin n_bad++; $display("FAIL ill_ctrl got %h want 0", ctrl[0]); end
        n_cmp++; if (wb_valid[0] !== 1'b1) begin n_bad++; $display("FAIL ill_older_wb_valid got %b want 1", wb_valid[0]); end
        n_cmp++; if (wb_addr[0] !== 5'd3) begin n_bad++; $display("FAIL ill_older_wb_addr got %0d want 3", wb_addr[0]); end
        n_cmp++; if (wb_data[0] !== 64'd12) begin n_bad++; $display("FAIL ill_older_wb_data got %h want c", wb_data[0]); end
        @(posedge clk); #1;
        n_cmp++; if (wb_valid[0] !== 1'b0) begin n_bad++; $display("FAIL ill_no_wb got %b want 0", wb_valid[0]); end
        pulse_ack();
        n_cmp++; if (trap[0] !== 1'b0) begin n_bad++; $display("FAIL ill_trap_clear got %b want 0", trap[0]); end
    endtask

    task automatic test_shift_lit();
        int s;
        do_reset();
        issue(0, 6'h12, 7'h39, 5'd10, 5'd2, 5'd31, 1'b1, 8'd4, 64'h500, s);
        n_cmp++; if (a_o[0] !== 64'd1) begin n_bad++; $display("FAIL sll_a got %h want 1", a_o[0]); end
        n_cmp++; if (b_o[0] !== 64'd4) begin n_bad++; $display("FAIL sll_b got %h want 4", b_o[0]); end
        n_cmp++; if (ctrl[0] !== 31'h0000_0080) begin n_bad++; $display("FAIL sll_ctrl got %h want 00000080", ctrl[0]); end
        issue(0, 6'h11, 7'h20, 5'd31, 5'd10, 5'd12, 1'b0, 8'd0, 64'h504, s);
        n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL r31_no_hazard got %0d want 0", s); end
        n_cmp++; if (wb_valid[0] !== 1'b0) begin n_bad++; $display("FAIL sll_r31_wb got %b want 0", wb_valid[0]); end
        n_cmp++; if (wb_data[0] !== 64'd16) begin n_bad++; $display("FAIL sll_result got %h want 10", wb_data[0]); end
        n_cmp++; if (a_o[0] !== 64'd0) begin n_bad++; $display("FAIL r31_reads_zero got %h want 0", a_o[0]); end
        n_cmp++; if (b_o[0] !== 64'd1) begin n_bad++; $display("FAIL bis_b got %h want 1", b_o[0]); end
        @(posedge clk); #1;
        n_cmp++; if (wb_valid[0] !== 1'b1) begin n_bad++; $display("FAIL bis_wb_valid got %b want 1", wb_valid[0]); end
        n_cmp++; if (wb_addr[0] !== 5'd12) begin n_bad++; $display("FAIL bis_wb_addr got %0d want 12", wb_addr[0]); end
        n_cmp++; if (wb_data[0] !== 64'd1) begin n_bad++; $display("FAIL bis_wb_data got %h want 1", wb_data[0]); end
    endtask

    task automatic test_reset_mid();
        int s;
        do_reset();
        issue(0, 6'h10, 7'h7F, 5'd4, 5'd5, 5'd9, 1'b0, 8'd0, 64'h600, s);
        n_cmp++; if (trap[0] !== 1'b1) begin n_bad++; $display("FAIL rstmid_trap_set got %b want 1", trap[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (trap[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_trap got %b want 0", trap[0]); end
        n_cmp++; if (trap_cause[0] !== 2'd0) begin n_bad++; $display("FAIL rstmid_cause got %0d want 0", trap_cause[0]); end
        n_cmp++; if (trap_pc[0] !== 64'd0) begin n_bad++; $display("FAIL rstmid_trap_pc got %h want 0", trap_pc[0]); end
        issue(0, 6'h10, 7'h60, 5'd6, 5'd0, 5'd7, 1'b1, 8'd1, 64'h610, s);
        n_cmp++; if (ctrl[0] !== 31'h0008_0001) begin n_bad++; $display("FAIL rstmid_ex_ctrl got %h want 00080001", ctrl[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (ctrl[0] !== 31'd0) begin n_bad++; $display("FAIL rstmid_ctrl got %h want 0", ctrl[0]); end
        n_cmp++; if (a_o[0] !== 64'd0) begin n_bad++; $display("FAIL rstmid_a got %h want 0", a_o[0]); end
        n_cmp++; if (b_o[0] !== 64'd0) begin n_bad++; $display("FAIL rstmid_b got %h want 0", b_o[0]); end
        n_cmp++; if (wb_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_wb0 got %b want 0", wb_valid[0]); end
        n_cmp++; if (trap[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_trap0 got %b want 0", trap[0]); end
        @(posedge clk); #1;
        n_cmp++; if (wb_valid[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_wb1 got %b want 0", wb_valid[0]); end
        n_cmp++; if (trap[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_trap1 got %b want 0", trap[0]); end
        n_cmp++; if (trap_cause[0] !== 2'd0) begin n_bad++; $display("FAIL rstmid_cause1 got %0d want 0", trap_cause[0]); end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_back_to_back();
        test_overflow();
        test_illegal();
        test_shift_lit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ibox_issue.md
# ibox_issue

Issue and writeback stage wrapped around the integer execution box. It accepts one decoded Alpha operate-format instruction per cycle and produces the registered `a`, `b` and 31-bit `control` word the Ibox consumes. It tracks the in-flight destination for hazard stall and bypass, returns the Ibox result to the register file, and converts the Ibox overflow flag or an unsupported function into a precise trap.

## Interface
- `BYPASS`, default 1: 1 forwards the WB result to operands; 0 stalls on RAW against WB as well as EX.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: combinational; instruction accepted on an edge where `in_valid & in_ready`.
- `in_opcode` in 6: instruction opcode.
- `in_func` in 7: instruction function field.
- `in_ra`, `in_rb`, `in_rc` in 5 each: source and destination register numbers.
- `in_lit_en` in 1: replace Rb with the literal.
- `in_lit` in 8: literal, zero-extended to 64 bits.
- `in_pc` in 64: instruction PC.
- `rf_a_addr`, `rf_b_addr` out 5 each: combinational copies of `in_ra` and `in_rb`.
- `rf_a_data`, `rf_b_data` in 64 each: combinational register-file read data.
- `a`, `b` out 64 each: registered Ibox operands.
- `control` out 31: registered Ibox control, packed as {n_shift[5:0], shifter[1:0], alu[3:0], cmp[2:0], mei[4:0], xor[2:0], mux0, mux1, mux2[2:0], mux3[1:0], v}.
- `ibox_result` in 64: Ibox registered result.
- `ibox_flag` in 1: Ibox overflow trap request, combinational from the current `control`.
- `wb_valid` out 1: register-file write enable.
- `wb_addr` out 5: write register number.
- `wb_data` out 64: write data, equal to `ibox_result`.
- `trap` out 1: trap pending.
- `trap_cause` out 2: 1 = overflow, 2 = illegal.
- `trap_pc` out 64: PC of the trapping instruction.
- `trap_ack` in 1: clears the trap.

## Operation
- Decode sets only the listed fields; every other control field is 0.
  - ADDQ 10.20: alu=1, mux2=0. ADDL 10.00: alu=1, mux2=1. SUBQ 10.29: alu=2. SUBL 10.09: alu=2, mux2=1.
  - /V forms ADDL 10.40, ADDQ 10.60, SUBL 10.49, SUBQ 10.69: base fields plus v=1.
  - CMPEQ 10.2D: alu=2, cmp=2, mux2=2. CMPLT 10.4D: cmp=0. CMPULT 10.1D: cmp=5. CMPLE 10.6D: cmp=3. CMPULE 10.3D: cmp=6.
  - AND 11.00: alu=3. BIS 11.20: alu=4. XOR 11.40: alu=5.
  - SLL 12.39: shifter=00, mux0=1. SRL 12.34: shifter=10, mux0=1. SRA 12.3C: shifter=11, mux0=1. All shifts use alu=0.
  - MULQ 13.20: alu=7. MULL 13.00: alu=8. UMULH 13.30: alu=9.
  - Any other opcode/function pair is illegal.
- Operand select:
  - Register 31 reads 0 and is never written (`wb_valid` 0 for rc=31).
  - Source is taken from `ibox_result` if `BYPASS`, `wb_valid`, and `wb_addr` equals the source; otherwise from `rf_*_data`.
  - `b` takes the literal when `in_lit_en`.
- Pipeline registers:
  - EX holds ex_valid, ex_rc, ex_pc, `a`, `b`, `control`.
  - WB holds `wb_valid` and `wb_addr`. A bubble sets control=0 and ex_valid=0.
- `in_ready` = RUN & !rst & !hazard & !ibox_flag.
  - hazard: ex_valid and ex_rc (≠31) equals `in_ra`, or equals `in_rb` with `in_lit_en`=0.
  - When `BYPASS`=0, the same comparison is made against WB.
- States:
  - RUN → TRAP on an edge where ex_valid & `ibox_flag`: cause 1, trap_pc=ex_pc. That instruction's `wb_valid` is forced to 0.
  - RUN → TRAP when an illegal instruction is accepted: it enters EX as a bubble; cause 2, trap_pc=in_pc.
  - Overflow wins over a same-edge illegal; the illegal is dropped.
  - TRAP: `in_ready`=0, EX loads bubbles. TRAP → RUN on an edge with `trap_ack`.

## Timing
- Accept at edge N → `a`/`b`/`control` valid after N.
- At edge N+1: Ibox registers the result, `wb_valid`/`wb_addr` load, and the trap is captured.
- Register file writes at edge N+2.
- Independent instructions: 1 per cycle.
- Dependent back-to-back pair: 1 bubble with `BYPASS`=1, 2 bubbles with `BYPASS`=0.
- `trap` rises the cycle after capture and falls the cycle after the `trap_ack` edge.
- Reset values:
  - `a`, `b`, `control`, `wb_addr`, `trap_pc`: 0.
  - `wb_valid`, `trap`, `trap_cause`, ex_valid: 0.
  - State: RUN. `in_ready`=0 while `rst` is high.
- Reset asserted mid-operation discards EX, WB and a pending trap at that edge.

## Test plan
- ADDQ r1=5, r2=7 → r3, then independent BIS → `control` carries alu=1, mux2=0. `wb_valid`/`wb_addr`=3 with `wb_data`=12 two cycles after accept. No stalls.
- ADDQ r1+r2→r3, then SUBQ r3−r1→r4 → one bubble, `b` or `a` bypassed from `ibox_result`=12, r4 written 7. Repeat with `BYPASS`=0 → two bubbles.
- ADDQ/V 0x7FFFFFFFFFFFFFFF+1 → `trap`=1, cause 1, trap_pc=that PC, `wb_valid`=0. The younger instruction is not issued. `trap_ack` → RUN.
- Opcode 10, func 7F → cause 2, no `wb_valid`. An older in-flight ADDQ still writes.
- SLL with `in_lit_en`, lit=4, r1=1 → `b`=4, mux0=1, result 16. Destination r31 → `wb_valid` stays 0.
- `rst` asserted while in TRAP and while EX is valid → all outputs return to their reset values next cycle. Neither the flushed instruction nor the trap produces a write or trap afterwards.
